// File: rtl/age_issue_queue_pkg.sv
// Shared sizing, entry layout and helpers for the age-ordered issue queue.
// Every queue file sizes itself from these constants.
package foxtrot_iq_pkg;

    localparam int INST_ID_BITS = 6;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;
    localparam int QUEUE_SIZE   = 8;
    localparam int WAKEUP_PORTS = 4;
    localparam int ISSUE_WIDTH  = 2;

    localparam int IDX_BITS = $clog2(QUEUE_SIZE);
    localparam int CNT_BITS = IDX_BITS + 1;

    typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_vec_t;
    typedef logic [WAKEUP_PORTS-1:0][PRN_BITS-1:0] wk_prn_t;

    typedef struct packed {
        logic                    valid;
        logic [INST_ID_BITS-1:0] inst_id;
        logic [31:0]             raw;
        logic [63:0]             pc;
        logic [MAX_OPERANDS-1:0] src_valid;
        logic [MAX_OPERANDS-1:0] src_ready;
        prn_vec_t                src_prn;
        prn_vec_t                dst_prn;
    } iq_entry_t;

    function automatic logic all_ready(input iq_entry_t e);
        return &e.src_ready;
    endfunction

    function automatic logic wake_hit(
        input logic [PRN_BITS-1:0]     prn,
        input logic [WAKEUP_PORTS-1:0] wv,
        input wk_prn_t                 wp
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKEUP_PORTS; w++) begin
            hit = hit | (wv[w] & (wp[w] == prn));
        end
        return hit;
    endfunction

    function automatic logic [CNT_BITS-1:0] pop_count(
        input logic [ISSUE_WIDTH-1:0] v
    );
        logic [CNT_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            c = c + CNT_BITS'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/age_issue_queue_if.sv
// Insert, wakeup-broadcast and issue-port bundle of the issue queue.
// master = renamer/FU side, slave = the queue itself.
interface age_issue_queue_if;
    import foxtrot_iq_pkg::*;

    logic                    ins_valid;
    logic                    ins_ready;
    logic [INST_ID_BITS-1:0] ins_inst_id;
    logic [31:0]             ins_raw;
    logic [63:0]             ins_pc;
    logic [MAX_OPERANDS-1:0] ins_src_valid;
    logic [MAX_OPERANDS-1:0] ins_src_ready;
    prn_vec_t                ins_src_prn;
    prn_vec_t                ins_dst_prn;

    logic [WAKEUP_PORTS-1:0] wk_valid;
    wk_prn_t                 wk_prn;

    logic [ISSUE_WIDTH-1:0]                        iss_valid;
    logic [ISSUE_WIDTH-1:0]                        iss_ready;
    logic [ISSUE_WIDTH-1:0][INST_ID_BITS-1:0]      iss_inst_id;
    logic [ISSUE_WIDTH-1:0][31:0]                  iss_raw;
    logic [ISSUE_WIDTH-1:0][63:0]                  iss_pc;
    logic [ISSUE_WIDTH-1:0][MAX_OPERANDS-1:0]      iss_src_valid;
    logic [ISSUE_WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] iss_src_prn;
    logic [ISSUE_WIDTH-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] iss_dst_prn;

    modport master (
        output ins_valid, ins_inst_id, ins_raw, ins_pc,
        output ins_src_valid, ins_src_ready, ins_src_prn, ins_dst_prn,
        output wk_valid, wk_prn, iss_ready,
        input  ins_ready, iss_valid, iss_inst_id, iss_raw, iss_pc,
        input  iss_src_valid, iss_src_prn, iss_dst_prn
    );

    modport slave (
        input  ins_valid, ins_inst_id, ins_raw, ins_pc,
        input  ins_src_valid, ins_src_ready, ins_src_prn, ins_dst_prn,
        input  wk_valid, wk_prn, iss_ready,
        output ins_ready, iss_valid, iss_inst_id, iss_raw, iss_pc,
        output iss_src_valid, iss_src_prn, iss_dst_prn
    );

endinterface

// File: rtl/age_issue_queue_select.sv
// Oldest-first picker: each issue port takes the oldest eligible entry
// not already granted to a lower-numbered port.
module age_matrix_select
    import foxtrot_iq_pkg::*;
(
    input  logic [QUEUE_SIZE-1:0]                  eligible,
    input  logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0]  older,
    output logic [ISSUE_WIDTH-1:0][QUEUE_SIZE-1:0] grant
);

    logic [QUEUE_SIZE-1:0] remaining;
    logic                  blocked;

    // An entry wins when no other remaining candidate is older than it.
    always_comb begin
        remaining = eligible;
        grant     = '0;
        blocked   = 1'b0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                blocked = 1'b0;
                for (int j = 0; j < QUEUE_SIZE; j++) begin
                    blocked = blocked | (remaining[j] & older[j][i]);
                end
                grant[p][i] = remaining[i] & ~blocked;
            end
            remaining = remaining & ~grant[p];
        end
    end

endmodule

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue: holds renamed instructions until their
// sources are ready and issues the oldest eligible ones first.
module age_issue_queue
    import foxtrot_iq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    age_issue_queue_if.slave    bus,
    output logic [CNT_BITS-1:0] occupancy
);

    iq_entry_t [QUEUE_SIZE-1:0]             entry_q, entry_d;
    logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0]  older_q, older_d;
    logic [CNT_BITS-1:0]                    occ_q, occ_d;

    logic [QUEUE_SIZE-1:0]                  valid_vec;
    logic [QUEUE_SIZE-1:0]                  eligible;
    logic [ISSUE_WIDTH-1:0][QUEUE_SIZE-1:0] grant;
    logic [ISSUE_WIDTH-1:0]                 iss_fire;
    logic [QUEUE_SIZE-1:0]                  deq;
    logic                                   ins_fire;
    logic [IDX_BITS-1:0]                    ins_idx;
    iq_entry_t                              new_entry;

    always_comb begin
        valid_vec = '0;
        eligible  = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            valid_vec[i] = entry_q[i].valid;
            eligible[i]  = entry_q[i].valid & all_ready(entry_q[i]);
        end
    end

    assign bus.ins_ready = ~&valid_vec;
    assign ins_fire      = bus.ins_valid & bus.ins_ready & ~flush;
    assign occupancy     = occ_q;

    always_comb begin
        ins_idx = '0;
        for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
            if (!valid_vec[i]) ins_idx = IDX_BITS'(i);
        end
    end

    // Sources woken in the insert cycle are captured as already ready.
    always_comb begin
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.inst_id   = bus.ins_inst_id;
        new_entry.raw       = bus.ins_raw;
        new_entry.pc        = bus.ins_pc;
        new_entry.src_valid = bus.ins_src_valid;
        new_entry.src_prn   = bus.ins_src_prn;
        new_entry.dst_prn   = bus.ins_dst_prn;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            new_entry.src_ready[k] = ~bus.ins_src_valid[k]
                | bus.ins_src_ready[k]
                | wake_hit(bus.ins_src_prn[k], bus.wk_valid, bus.wk_prn);
        end
    end

    age_matrix_select u_select (
        .eligible (eligible),
        .older    (older_q),
        .grant    (grant)
    );

    always_comb begin
        bus.iss_valid     = '0;
        bus.iss_inst_id   = '0;
        bus.iss_raw       = '0;
        bus.iss_pc        = '0;
        bus.iss_src_valid = '0;
        bus.iss_src_prn   = '0;
        bus.iss_dst_prn   = '0;
        iss_fire          = '0;
        deq               = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            bus.iss_valid[p] = (|grant[p]) & ~flush;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                if (grant[p][i]) begin
                    bus.iss_inst_id[p]   = entry_q[i].inst_id;
                    bus.iss_raw[p]       = entry_q[i].raw;
                    bus.iss_pc[p]        = entry_q[i].pc;
                    bus.iss_src_valid[p] = entry_q[i].src_valid;
                    bus.iss_src_prn[p]   = entry_q[i].src_prn;
                    bus.iss_dst_prn[p]   = entry_q[i].dst_prn;
                end
            end
            iss_fire[p] = bus.iss_valid[p] & bus.iss_ready[p];
            if (iss_fire[p]) deq = deq | grant[p];
        end
    end

    always_comb begin
        entry_d = entry_q;
        older_d = older_q;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (entry_q[i].valid) begin
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    if (wake_hit(entry_q[i].src_prn[k], bus.wk_valid,
                                 bus.wk_prn)) begin
                        entry_d[i].src_ready[k] = 1'b1;
                    end
                end
            end
            if (deq[i]) entry_d[i].valid = 1'b0;
        end
        // Newcomer is younger than everything currently held.
        if (ins_fire) begin
            entry_d[ins_idx] = new_entry;
            for (int j = 0; j < QUEUE_SIZE; j++) begin
                older_d[ins_idx][j] = 1'b0;
                older_d[j][ins_idx] = valid_vec[j];
            end
        end
        occ_d = occ_q + CNT_BITS'(ins_fire) - pop_count(iss_fire);
        if (flush) begin
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                entry_d[i].valid = 1'b0;
            end
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
            older_q <= '0;
            occ_q   <= '0;
        end else begin
            entry_q <= entry_d;
            older_q <= older_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_age_issue_queue.sv
// Scoreboard bench for age_issue_queue: an ordered-list reference model
// predicts each cycle's outputs and a negedge monitor compares them.
module tb_age_issue_queue;
    import foxtrot_iq_pkg::*;

    typedef struct packed {
        logic [INST_ID_BITS-1:0] id;
        logic [31:0]             raw;
        logic [63:0]             pc;
        logic [MAX_OPERANDS-1:0] sv;
        prn_vec_t                sp;
        prn_vec_t                dp;
    } pay_t;

    typedef struct packed {
        pay_t                    pay;
        logic [MAX_OPERANDS-1:0] rdy;
    } ment_t;

    typedef struct packed {
        logic [CNT_BITS-1:0]           occ;
        logic                          ready;
        logic [ISSUE_WIDTH-1:0]        vld;
        pay_t [ISSUE_WIDTH-1:0]        pay;
    } exp_t;

    typedef struct packed {
        logic                    ins_valid;
        pay_t                    pay;
        logic [MAX_OPERANDS-1:0] srdy;
        logic [WAKEUP_PORTS-1:0] wk_valid;
        wk_prn_t                 wk_prn;
        logic [ISSUE_WIDTH-1:0]  iss_ready;
        logic                    flush;
    } stim_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [CNT_BITS-1:0] occupancy;

    age_issue_queue_if bus ();

    age_issue_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int    checks   = 0;
    int    failures = 0;
    ment_t mq[$];
    exp_t  expq[$];
    exp_t  me;
    pay_t  dp;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    function automatic logic woke(input logic [PRN_BITS-1:0] prn,
                                  input stim_t s);
        for (int w = 0; w < WAKEUP_PORTS; w++) begin
            if (s.wk_valid[w] && s.wk_prn[w] == prn) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic stim_t idle(input logic [1:0] rdy);
        stim_t s;
        s = '0;
        s.iss_ready = rdy;
        return s;
    endfunction

    function automatic stim_t ins(input int id, input logic [2:0] sv,
                                  input logic [2:0] srdy,
                                  input logic [PRN_BITS-1:0] prn);
        stim_t s;
        s = '0;
        s.ins_valid = 1'b1;
        s.pay.id    = INST_ID_BITS'(id);
        s.pay.raw   = $urandom;
        s.pay.pc    = {$urandom, $urandom};
        s.pay.sv    = sv;
        s.pay.sp    = {3{prn}};
        s.pay.dp    = prn_vec_t'({$urandom, $urandom});
        s.srdy      = srdy;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.ins_valid     = s.ins_valid;
        bus.ins_inst_id   = s.pay.id;
        bus.ins_raw       = s.pay.raw;
        bus.ins_pc        = s.pay.pc;
        bus.ins_src_valid = s.pay.sv;
        bus.ins_src_ready = s.srdy;
        bus.ins_src_prn   = s.pay.sp;
        bus.ins_dst_prn   = s.pay.dp;
        bus.wk_valid      = s.wk_valid;
        bus.wk_prn        = s.wk_prn;
        bus.iss_ready     = s.iss_ready;
        flush             = s.flush;
    endtask

    // Model: mq is kept oldest-first; issue = first ready entries in order.
    task automatic step(input stim_t s);
        exp_t  e;
        ment_t m;
        int    picks[$];
        @(posedge clk);
        #1;
        drive(s);
        e       = '0;
        e.occ   = CNT_BITS'(mq.size());
        e.ready = (mq.size() < QUEUE_SIZE);
        if (!s.flush) begin
            foreach (mq[i]) begin
                if (&mq[i].rdy && picks.size() < ISSUE_WIDTH) picks.push_back(i);
            end
        end
        foreach (picks[p]) begin
            e.vld[p] = 1'b1;
            e.pay[p] = mq[picks[p]].pay;
        end
        expq.push_back(e);
        if (s.flush) begin
            mq.delete();
        end else begin
            for (int p = picks.size() - 1; p >= 0; p--) begin
                if (s.iss_ready[p]) mq.delete(picks[p]);
            end
            foreach (mq[i]) begin
                m = mq[i];
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    if (woke(m.pay.sp[k], s)) m.rdy[k] = 1'b1;
                end
                mq[i] = m;
            end
            if (s.ins_valid && e.ready) begin
                m.pay = s.pay;
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    m.rdy[k] = !s.pay.sv[k] || s.srdy[k] || woke(s.pay.sp[k], s);
                end
                mq.push_back(m);
            end
        end
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #2;
        drive(idle(2'b00));
        rst = 1'b1;
        #1;
        chk("async_occ", occupancy, 0);
        chk("async_ins_ready", bus.ins_ready, 1);
        chk("async_iss_valid", bus.iss_valid, 0);
        #1;
        rst = 1'b0;
        mq.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                me = expq.pop_front();
                chk("occupancy", occupancy, me.occ);
                chk("ins_ready", bus.ins_ready, me.ready);
                chk("iss_valid", bus.iss_valid, me.vld);
                for (int p = 0; p < ISSUE_WIDTH; p++) begin
                    if (me.vld[p]) begin
                        dp = {bus.iss_inst_id[p], bus.iss_raw[p], bus.iss_pc[p],
                              bus.iss_src_valid[p], bus.iss_src_prn[p],
                              bus.iss_dst_prn[p]};
                        chk($sformatf("payload_p%0d", p), dp, me.pay[p]);
                    end
                end
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        drive(idle(2'b00));
        #3;
        chk("rst_occ", occupancy, 0);
        chk("rst_ins_ready", bus.ins_ready, 1);
        chk("rst_iss_valid", bus.iss_valid, 0);
        chk("rst_iss_id", bus.iss_inst_id, 0);
        #9;
        rst = 1'b0;

        s = ins(5, 3'b111, 3'b111, 0);
        s.iss_ready = 2'b11;
        step(s);
        repeat (2) step(idle(2'b11));

        for (int id = 1; id <= 3; id++) begin
            s = ins(id, 3'b001, 3'b000, 10);
            s.iss_ready = 2'b11;
            step(s);
        end
        s = idle(2'b11);
        s.wk_valid[0] = 1'b1;
        s.wk_prn[0]   = 10;
        step(s);
        repeat (3) step(idle(2'b11));

        s = ins(7, 3'b001, 3'b000, 20);
        s.wk_valid[2] = 1'b1;
        s.wk_prn[2]   = 20;
        s.iss_ready   = 2'b11;
        step(s);
        repeat (2) step(idle(2'b11));

        for (int i = 0; i < QUEUE_SIZE; i++) step(ins(8 + i, 3'b001, 3'b000, 30));
        step(idle(2'b00));
        s = idle(2'b00);
        s.wk_valid[1] = 1'b1;
        s.wk_prn[1]   = 30;
        step(s);
        s = ins(50, 3'b111, 3'b111, 0);
        s.iss_ready = 2'b10;
        step(s);
        step(ins(40, 3'b111, 3'b111, 0));
        repeat (6) step(idle(2'b11));

        for (int i = 0; i < 5; i++) step(ins(20 + i, 3'b111, 3'b111, 0));
        s = ins(60, 3'b111, 3'b111, 0);
        s.flush     = 1'b1;
        s.iss_ready = 2'b11;
        step(s);
        repeat (2) step(idle(2'b11));

        for (int i = 0; i < 3; i++) step(ins(30 + i, 3'b111, 3'b111, 0));
        step(idle(2'b00));
        rst_pulse();
        repeat (2) step(idle(2'b11));

        for (int c = 0; c < 2000; c++) begin
            s = ins($urandom_range(0, 63), 3'($urandom), 3'($urandom), 0);
            s.ins_valid = ($urandom_range(0, 9) < 6);
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                s.pay.sp[k] = PRN_BITS'($urandom_range(0, 15));
            end
            for (int w = 0; w < WAKEUP_PORTS; w++) begin
                s.wk_valid[w] = ($urandom_range(0, 3) == 0);
                s.wk_prn[w]   = PRN_BITS'($urandom_range(0, 15));
            end
            s.iss_ready = 2'($urandom);
            s.flush     = ($urandom_range(0, 63) == 0);
            step(s);
        end
        step(idle(2'b00));
        @(negedge clk);
        #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
